// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multicycle sequencer (master) and the datapath (slave).
interface multicycle_ctrl_fsm_if #(
    parameter int unsigned CNT_W = 16
);
    logic [15:0]      instr;
    logic             mem_ready;
    logic             alu_zero;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             mem_req;
    logic             mem_we;
    logic             mem_addr_sel;
    logic [1:0]       alu_op;
    logic             alu_srcb;
    logic             rf_we;
    logic [1:0]       reg_destsel;
    logic [1:0]       wb_sel;
    logic [2:0]       state_o;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] instr_retired;

    modport master (
        input  instr, mem_ready, alu_zero,
        output ir_we, pc_we, pc_src, mem_req, mem_we, mem_addr_sel, alu_op, alu_srcb,
               rf_we, reg_destsel, wb_sel, state_o, halted, illegal, instr_retired
    );

    modport slave (
        output instr, mem_ready, alu_zero,
        input  ir_we, pc_we, pc_src, mem_req, mem_we, mem_addr_sel, alu_op, alu_srcb,
               rf_we, reg_destsel, wb_sel, state_o, halted, illegal, instr_retired
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit RISC core.
// Moore outputs are registered from the next state; ir_we/pc_we/pc_src take late qualifiers.
module multicycle_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    multicycle_ctrl_fsm_if.master bus
);
    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd7
    } state_e;

    localparam logic [7:0] TimeoutVal = 8'(MEM_TIMEOUT);

    logic [3:0] opcode;
    logic       is_add, is_adi, is_nand, is_lhi, is_lw, is_sw, is_beq, is_jal, is_jlr, legal;
    logic       unused_instr_bits;

    assign opcode            = bus.instr[15:12];
    assign unused_instr_bits = ^bus.instr[11:0];
    assign is_add  = (opcode == 4'h0);
    assign is_adi  = (opcode == 4'h1);
    assign is_nand = (opcode == 4'h2);
    assign is_lhi  = (opcode == 4'h3);
    assign is_lw   = (opcode == 4'h4);
    assign is_sw   = (opcode == 4'h5);
    assign is_jal  = (opcode == 4'h8);
    assign is_jlr  = (opcode == 4'h9);
    assign is_beq  = (opcode == 4'hC);
    assign legal   = is_add | is_adi | is_nand | is_lhi | is_lw | is_sw | is_jal | is_jlr | is_beq;

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic             halted_q, halted_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic             mem_addr_sel_q, mem_addr_sel_d;
    logic [1:0]       alu_op_q, alu_op_d;
    logic             alu_srcb_q, alu_srcb_d;
    logic             rf_we_q, rf_we_d;
    logic [1:0]       reg_destsel_q, reg_destsel_d;
    logic [1:0]       wb_sel_q, wb_sel_d;
    logic             pc_we_q, pc_we_d;
    logic [1:0]       pc_src_q, pc_src_d;
    logic             beq_exec_q, beq_exec_d;
    logic             mem_timeout;

    assign mem_timeout = !bus.mem_ready && (wait_q == TimeoutVal);

    always_comb begin
        state_d   = state_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
        wait_d    = wait_q;
        unique case (state_q)
            StFetch: begin
                if (bus.mem_ready)    state_d = StDecode;
                else if (mem_timeout) state_d = StHalt;
            end
            StDecode: state_d = legal ? StExec : StHalt;
            StExec: begin
                if (is_lw || is_sw) state_d = StMem;
                else if (is_beq)    state_d = StFetch;
                else                state_d = StWb;
            end
            StMem: begin
                if (bus.mem_ready)    state_d = is_lw ? StWb : StFetch;
                else if (mem_timeout) state_d = StHalt;
            end
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StHalt;
        endcase

        if (state_d == StHalt && state_q != StHalt) begin
            halted_d  = 1'b1;
            illegal_d = (state_q == StDecode);
        end
        if (state_d == StFetch &&
            (state_q == StExec || state_q == StMem || state_q == StWb)) begin
            retired_d = retired_q + CNT_W'(1);
        end
        // Any state change clears the wait counter, so it starts fresh in FETCH and MEM.
        if (state_d != state_q)                wait_d = 8'd0;
        else if (mem_req_q && !bus.mem_ready) wait_d = wait_q + 8'd1;
    end

    always_comb begin
        mem_req_d      = (state_d == StFetch) || (state_d == StMem);
        mem_addr_sel_d = (state_d == StMem);
        mem_we_d       = (state_d == StMem) && is_sw;
        alu_op_d       = 2'b00;
        alu_srcb_d     = 1'b0;
        rf_we_d        = (state_d == StWb);
        reg_destsel_d  = 2'b11;
        wb_sel_d       = 2'b00;
        pc_we_d        = (state_d == StWb) || ((state_d == StExec) && is_beq);
        pc_src_d       = 2'b00;
        beq_exec_d     = (state_d == StExec) && is_beq;
        if (state_d == StExec) begin
            alu_srcb_d = is_adi | is_lw | is_sw;
            if (is_nand)     alu_op_d = 2'b01;
            else if (is_beq) alu_op_d = 2'b10;
            else if (is_lhi) alu_op_d = 2'b11;
        end
        if (state_d == StWb) begin
            if (is_add || is_nand) reg_destsel_d = 2'b10;
            else if (is_adi)       reg_destsel_d = 2'b01;
            else                   reg_destsel_d = 2'b00;
            if (is_lw)                 wb_sel_d = 2'b01;
            else if (is_lhi)           wb_sel_d = 2'b10;
            else if (is_jal || is_jlr) wb_sel_d = 2'b11;
            if (is_jal)      pc_src_d = 2'b11;
            else if (is_jlr) pc_src_d = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StFetch;
            wait_q         <= 8'd0;
            halted_q       <= 1'b0;
            illegal_q      <= 1'b0;
            retired_q      <= '0;
            mem_req_q      <= 1'b1;
            mem_we_q       <= 1'b0;
            mem_addr_sel_q <= 1'b0;
            alu_op_q       <= 2'b00;
            alu_srcb_q     <= 1'b0;
            rf_we_q        <= 1'b0;
            reg_destsel_q  <= 2'b11;
            wb_sel_q       <= 2'b00;
            pc_we_q        <= 1'b0;
            pc_src_q       <= 2'b00;
            beq_exec_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_q         <= wait_d;
            halted_q       <= halted_d;
            illegal_q      <= illegal_d;
            retired_q      <= retired_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_sel_q <= mem_addr_sel_d;
            alu_op_q       <= alu_op_d;
            alu_srcb_q     <= alu_srcb_d;
            rf_we_q        <= rf_we_d;
            reg_destsel_q  <= reg_destsel_d;
            wb_sel_q       <= wb_sel_d;
            pc_we_q        <= pc_we_d;
            pc_src_q       <= pc_src_d;
            beq_exec_q     <= beq_exec_d;
        end
    end

    // mem_we_q is only high in MEM for SW, which retires with a PC+1 update on ready.
    assign bus.ir_we         = (state_q == StFetch) && bus.mem_ready;
    assign bus.pc_we         = pc_we_q || (mem_we_q && bus.mem_ready);
    assign bus.pc_src        = beq_exec_q ? {1'b0, bus.alu_zero} : pc_src_q;
    assign bus.mem_req       = mem_req_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr_sel  = mem_addr_sel_q;
    assign bus.alu_op        = alu_op_q;
    assign bus.alu_srcb      = alu_srcb_q;
    assign bus.rf_we         = rf_we_q;
    assign bus.reg_destsel   = reg_destsel_q;
    assign bus.wb_sel        = wb_sel_q;
    assign bus.state_o       = state_q;
    assign bus.halted        = halted_q;
    assign bus.illegal       = illegal_q;
    assign bus.instr_retired = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: directed scenarios plus a randomized run,
// all compared every cycle against an instruction-level reference model.
module tb_multicycle_ctrl_fsm;
    localparam int unsigned TO = 15;
    localparam int unsigned CW = 4;
    localparam int unsigned OW = 20 + CW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if #(.CNT_W(CW)) bus ();
    multicycle_ctrl_fsm #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [OW-1:0] obs;
    assign obs = {bus.state_o, bus.halted, bus.illegal, bus.ir_we, bus.pc_we, bus.pc_src,
                  bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.alu_op, bus.alu_srcb,
                  bus.rf_we, bus.reg_destsel, bus.wb_sel, bus.instr_retired};

    typedef struct packed {
        logic       legal, lw, sw, beq, srcb, aluop_def;
        logic [1:0] dest, wb, aluop, wbpc;
    } info_t;

    int            m_state, m_wait, m_retired;
    logic          m_halted, m_illegal;
    logic [OW-1:0] e_out, e_msk;
    int            n_vec = 0;
    int            n_err = 0;

    // Instruction classes as seen by the sequencer.
    function automatic info_t classify(input logic [3:0] op);
        info_t r;
        r = '0;
        r.legal = 1'b1;
        case (op)
            4'h0: begin r.dest = 2'b10; r.aluop_def = 1'b1; end
            4'h2: begin r.dest = 2'b10; r.aluop = 2'b01; r.aluop_def = 1'b1; end
            4'h1: begin r.dest = 2'b01; r.srcb = 1'b1; r.aluop_def = 1'b1; end
            4'h3: begin r.wb = 2'b10; end
            4'h4: begin r.lw = 1'b1; r.wb = 2'b01; r.srcb = 1'b1; r.aluop_def = 1'b1; end
            4'h5: begin r.sw = 1'b1; r.srcb = 1'b1; r.aluop_def = 1'b1; end
            4'h8: begin r.wb = 2'b11; r.wbpc = 2'b11; end
            4'h9: begin r.wb = 2'b11; r.wbpc = 2'b10; end
            4'hC: begin r.beq = 1'b1; r.aluop = 2'b10; r.aluop_def = 1'b1; end
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_wait = 0; m_retired = 0; m_halted = 1'b0; m_illegal = 1'b0;
    endtask

    task automatic model_expect(input logic [15:0] ins, input logic mr, input logic az);
        info_t      i;
        logic       pcwe;
        logic [1:0] pcsrc;
        i     = classify(ins[15:12]);
        pcwe  = (m_state == 4) || (m_state == 2 && i.beq) || (m_state == 3 && i.sw && mr);
        pcsrc = (m_state == 2) ? {1'b0, az} : (m_state == 4) ? i.wbpc : 2'b00;
        e_out = {3'(m_state), m_halted, m_illegal, (m_state == 0) && mr, pcwe, pcsrc,
                 (m_state == 0 || m_state == 3), (m_state == 3 && i.sw), (m_state == 3),
                 i.aluop, i.srcb, (m_state == 4), (m_state == 4) ? i.dest : 2'b11, i.wb,
                 CW'(m_retired)};
        e_msk = {3'b111, 4'b1111, pcwe ? 2'b11 : 2'b00, 2'b11,
                 (m_state == 0 || m_state == 3), (m_state == 2 && i.aluop_def) ? 2'b11 : 2'b00,
                 (m_state == 2), 3'b111, (m_state == 4) ? 2'b11 : 2'b00, {CW{1'b1}}};
    endtask

    task automatic model_advance(input logic [15:0] ins, input logic mr);
        info_t i;
        int    nxt;
        i   = classify(ins[15:12]);
        nxt = m_state;
        case (m_state)
            0: if (mr) nxt = 1; else if (m_wait == TO) nxt = 7;
            1: nxt = i.legal ? 2 : 7;
            2: nxt = (i.lw || i.sw) ? 3 : (i.beq ? 0 : 4);
            3: if (mr) nxt = i.lw ? 4 : 0; else if (m_wait == TO) nxt = 7;
            4: nxt = 0;
            default: nxt = 7;
        endcase
        if (nxt == 7 && m_state != 7) begin m_halted = 1'b1; m_illegal = (m_state == 1); end
        if (nxt == 0 && m_state >= 2 && m_state <= 4) m_retired = (m_retired + 1) % (1 << CW);
        if (nxt != m_state) m_wait = 0;
        else if ((m_state == 0 || m_state == 3) && !mr) m_wait = m_wait + 1;
        m_state = nxt;
    endtask

    // Drive one cycle at the falling edge, settle, and prepare the expected outputs.
    task automatic cycle(input logic rst, input logic [15:0] ins, input logic mr, input logic az);
        @(negedge clk);
        rst_n = rst; bus.instr = ins; bus.mem_ready = mr; bus.alu_zero = az;
        #1;
        if (!rst) model_reset();
        model_expect(ins, mr, az);
        if (rst) model_advance(ins, mr);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, 16'(($urandom & 32'hFFFF)), 1'b0, 1'($urandom));
            n_vec++;
            if ((obs & e_msk) !== (e_out & e_msk)) begin
                n_err++; $display("FAIL reset c%0d: got %h want %h", c, obs & e_msk, e_out & e_msk);
            end
        end
        n_vec++;
        if (bus.rf_we !== 1'b0 || bus.reg_destsel !== 2'b11 || bus.instr_retired !== '0) begin
            n_err++; $display("FAIL reset_vals: got rf_we=%b dest=%b ret=%0d want 0/11/0",
                              bus.rf_we, bus.reg_destsel, bus.instr_retired);
        end
    endtask

    task automatic test_add();
        int n_rf = 0;
        cycle(1'b0, 16'h0A98, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            cycle(1'b1, 16'h0A98, (c == 0), 1'($urandom));
            n_vec++;
            if ((obs & e_msk) !== (e_out & e_msk)) begin
                n_err++; $display("FAIL add c%0d: got %h want %h", c, obs & e_msk, e_out & e_msk);
            end
            if (bus.rf_we) n_rf++;
        end
        n_vec++;
        if (n_rf != 1 || bus.state_o !== 3'd0 || bus.instr_retired !== 4'd1) begin
            n_err++; $display("FAIL add_end: got rf=%0d st=%0d ret=%0d want 1/0/1",
                              n_rf, bus.state_o, bus.instr_retired);
        end
    endtask

    task automatic test_lw();
        int n_req = 0;
        cycle(1'b0, 16'h4A85, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            cycle(1'b1, 16'h4A85, (m_state == 0) || (m_state == 3 && m_wait == 3), 1'b0);
            n_vec++;
            if ((obs & e_msk) !== (e_out & e_msk)) begin
                n_err++; $display("FAIL lw c%0d: got %h want %h", c, obs & e_msk, e_out & e_msk);
            end
            if (bus.mem_req && bus.mem_addr_sel) n_req++;
        end
        n_vec++;
        if (n_req != 4 || bus.reg_destsel !== 2'b00 || bus.wb_sel !== 2'b01) begin
            n_err++; $display("FAIL lw_mem: got req=%0d dest=%b wb=%b want 4/00/01",
                              n_req, bus.reg_destsel, bus.wb_sel);
        end
    endtask

    task automatic test_beq_sw();
        logic [15:0] prog [0:2];
        prog[0] = 16'hC283; prog[1] = 16'hC283; prog[2] = 16'h5A85;
        cycle(1'b0, prog[0], 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 6; c++) begin
                cycle(1'b1, prog[k], (m_state == 0 && c == 0) || (m_state == 3 && m_wait == 1),
                      (k == 0));
                n_vec++;
                if ((obs & e_msk) !== (e_out & e_msk)) begin
                    n_err++;
                    $display("FAIL beq_sw k%0d c%0d: got %h want %h", k, c, obs & e_msk,
                             e_out & e_msk);
                end
                if (k < 2 && c == 2) begin
                    n_vec++;
                    if (bus.pc_we !== 1'b1 || bus.pc_src !== ((k == 0) ? 2'b01 : 2'b00) ||
                        bus.rf_we !== 1'b0) begin
                        n_err++; $display("FAIL beq_exec k%0d: got pc_we=%b src=%b rf=%b",
                                          k, bus.pc_we, bus.pc_src, bus.rf_we);
                    end
                end
            end
        end
    endtask

    task automatic test_illegal();
        cycle(1'b0, 16'hF123, 1'b0, 1'b0);
        for (int c = 0; c < 22; c++) begin
            cycle(1'b1, 16'hF123, (c == 0) ? 1'b1 : 1'($urandom), 1'($urandom));
            n_vec++;
            if ((obs & e_msk) !== (e_out & e_msk)) begin
                n_err++; $display("FAIL illegal c%0d: got %h want %h", c, obs & e_msk,
                                  e_out & e_msk);
            end
        end
        n_vec++;
        if (bus.state_o !== 3'd7 || bus.halted !== 1'b1 || bus.illegal !== 1'b1) begin
            n_err++; $display("FAIL illegal_hold: got st=%0d h=%b i=%b want 7/1/1",
                              bus.state_o, bus.halted, bus.illegal);
        end
        cycle(1'b0, 16'hF123, 1'b0, 1'b0);
        n_vec++;
        if (bus.halted !== 1'b0 || bus.illegal !== 1'b0 || bus.state_o !== 3'd0) begin
            n_err++; $display("FAIL illegal_clear: got h=%b i=%b st=%0d want 0/0/0",
                              bus.halted, bus.illegal, bus.state_o);
        end
    endtask

    task automatic test_timeout();
        cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        for (int c = 0; c < int'(TO) + 3; c++) begin
            cycle(1'b1, 16'h0000, 1'b0, 1'b0);
            n_vec++;
            if ((obs & e_msk) !== (e_out & e_msk)) begin
                n_err++; $display("FAIL tmo c%0d: got %h want %h", c, obs & e_msk, e_out & e_msk);
            end
            if (c == int'(TO) + 1) begin
                n_vec++;
                if (bus.state_o !== 3'd7 || bus.halted !== 1'b1 || bus.illegal !== 1'b0) begin
                    n_err++; $display("FAIL tmo_halt: got st=%0d h=%b i=%b want 7/1/0",
                                      bus.state_o, bus.halted, bus.illegal);
                end
            end
        end
        cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        for (int c = 0; c <= int'(TO) + 1; c++) begin
            cycle(1'b1, 16'h0000, (c == int'(TO)), 1'b0);
            n_vec++;
            if ((obs & e_msk) !== (e_out & e_msk)) begin
                n_err++; $display("FAIL tmo_last c%0d: got %h want %h", c, obs & e_msk,
                                  e_out & e_msk);
            end
        end
        n_vec++;
        if (bus.state_o !== 3'd1 || bus.halted !== 1'b0) begin
            n_err++; $display("FAIL tmo_ready: got st=%0d h=%b want 1/0", bus.state_o, bus.halted);
        end
    endtask

    task automatic test_reset_in_wb();
        cycle(1'b0, 16'h1A85, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            cycle(1'b1, 16'h1A85, (c == 0), 1'b0);
            n_vec++;
            if ((obs & e_msk) !== (e_out & e_msk)) begin
                n_err++; $display("FAIL adi c%0d: got %h want %h", c, obs & e_msk, e_out & e_msk);
            end
        end
        n_vec++;
        if (bus.rf_we !== 1'b1 || bus.reg_destsel !== 2'b01) begin
            n_err++; $display("FAIL adi_wb: got rf=%b dest=%b want 1/01", bus.rf_we,
                              bus.reg_destsel);
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        model_expect(16'h1A85, 1'b0, 1'b0);
        n_vec++;
        if ((obs & e_msk) !== (e_out & e_msk) || bus.rf_we !== 1'b0 || bus.state_o !== 3'd0) begin
            n_err++; $display("FAIL wb_abort: got %h want %h", obs & e_msk, e_out & e_msk);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 16'h2A98, 1'b0, 1'b0);
        for (int c = 0; c < 16 * 4 + 1; c++) begin
            cycle(1'b1, 16'h2A98, (m_state == 0) && (c < 64), 1'b0);
            n_vec++;
            if ((obs & e_msk) !== (e_out & e_msk)) begin
                n_err++; $display("FAIL wrap c%0d: got %h want %h", c, obs & e_msk, e_out & e_msk);
            end
        end
        n_vec++;
        if (bus.instr_retired !== '0 || bus.state_o !== 3'd0) begin
            n_err++; $display("FAIL wrap_zero: got ret=%0d st=%0d want 0/0", bus.instr_retired,
                              bus.state_o);
        end
    endtask

    task automatic test_random();
        logic [3:0]  ops [0:8];
        logic [15:0] cur;
        logic        rst, mr;
        int          halt_cyc = 0;
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hC};
        cur = 16'h0000;
        cycle(1'b0, cur, 1'b0, 1'b0);
        for (int c = 0; c < 500; c++) begin
            if (m_state == 0) begin
                cur[11:0]  = 12'($urandom);
                cur[15:12] = ($urandom_range(0, 19) == 0) ? 4'($urandom) :
                                                            ops[$urandom_range(0, 8)];
            end
            halt_cyc = m_halted ? halt_cyc + 1 : 0;
            rst = !(halt_cyc > 3 || $urandom_range(0, 99) == 0);
            mr  = rst && ($urandom_range(0, 9) < 7);
            cycle(rst, cur, mr, 1'($urandom));
            n_vec++;
            if ((obs & e_msk) !== (e_out & e_msk)) begin
                n_err++; $display("FAIL rand c%0d instr=%h: got %h want %h", c, cur,
                                  obs & e_msk, e_out & e_msk);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; bus.instr = '0; bus.mem_ready = 1'b0; bus.alu_zero = 1'b0;
        model_reset();
        test_reset();
        test_add();
        test_lw();
        test_beq_sw();
        test_illegal();
        test_timeout();
        test_reset_in_wb();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
